pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core's pipe registers (PC, IF/ID, ID/EX, EX/MEM).
//  Detects load-use hazards, EX-resolved branch/jump redirects and multi-cycle EX ops (mul/div).
//  Issues per-register stall/flush strobes each cycle.
//  Inserts post-reset and post-redirect bubbles covering the registered BRAM instruction-fetch latency.
// PARAMETERS
//  FETCH_LAT   1   cycles of BRAM fetch latency to squash after reset release / redirect (1..7)
//  CNT_W       32  width of perf counters (used only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk          in   1   core clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  id_rs1       in   5   rs1 index of instr in ID
//  id_rs2       in   5   rs2 index of instr in ID
//  id_use_rs1   in   1   ID instr reads rs1
//  id_use_rs2   in   1   ID instr reads rs2
//  ex_rd        in   5   rd of instr in EX
//  ex_is_load   in   1   EX instr is a load
//  ex_redirect  in   1   EX resolved taken branch/jump; PC mux already selects target
//  ex_mc_start  in   1   EX instr launches multi-cycle unit (pulse, first EX cycle)
//  mc_done      in   1   multi-cycle unit result valid (pulse)
//  stall_pc     out  1   hold PC
//  stall_if_id  out  1   hold IF/ID
//  flush_if_id  out  1   bubble IF/ID (also zeroes instr passed to decode)
//  stall_id_ex  out  1   hold ID/EX
//  flush_id_ex  out  1   bubble ID/EX
//  flush_ex_mem out  1   bubble EX/MEM
// BEHAVIOUR
//  FSM states: SQUASH, RUN, MC_WAIT. 3-bit squash counter sq_cnt.
//  Reset (async, any time incl. mid-MC_WAIT): state=SQUASH, sq_cnt=FETCH_LAT.
//   Outputs during reset: flush_if_id=1, flush_id_ex=1, all others 0.
//  SQUASH: flush_if_id=1, flush_id_ex=1, no stalls; sq_cnt-- each cycle; sq_cnt==1 -> RUN.
//  RUN, priority highest first:
//   1) ex_redirect: flush_if_id=1, flush_id_ex=1 same cycle.
//      FETCH_LAT==1 -> stay RUN (next cycle is first correct-path cycle with no extra bubble).
//      FETCH_LAT>1 -> SQUASH with sq_cnt=FETCH_LAT-1.
//      Redirect beats any load-use on the same cycle (ID instr is wrong-path): no stall.
//   2) ex_mc_start: -> MC_WAIT; stall_pc, stall_if_id, stall_id_ex, flush_ex_mem =1 this cycle.
//   3) load-use: ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//      -> stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly that cycle; stay RUN.
//      Next cycle EX holds the bubble, so the hazard clears by construction (1-cycle penalty).
//   4) else all outputs 0.
//  MC_WAIT:
//   - stall_pc, stall_if_id, stall_id_ex, flush_ex_mem =1 every cycle until mc_done.
//   - mc_done cycle: all 0 (EX result advances), -> RUN.
//   - ex_redirect and mc_done together: treat as RUN rule 1 on that cycle.
//   - ex_redirect without mc_done is ignored. ex_mc_start is ignored.
//  Outputs are combinational from state + inputs; no registered latency. stall_* never asserted with same-reg flush_*.
//  x/4'd0 rd (x0) never causes a load-use stall.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cyc, perf_flush_cyc [CNT_W-1:0].
//   - perf_stall_cyc +1 per cycle with stall_pc=1.
//   - perf_flush_cyc +1 per cycle with flush_if_id=1 after SQUASH-from-reset completes.
//   - Counters wrap at 2^CNT_W; reset to 0.
//  PIPE_CTRL_PERF_EN undefined: ports and counters absent; control behaviour identical.
// TESTING
//  Reset, FETCH_LAT=2: release rst_n -> flush_if_id=flush_id_ex=1 for 2 cycles, then all 0 in RUN.
//  Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle only.
//  Load-use with ex_rd=0 or id_use_rs2=0 -> no stall.
//  Redirect+hazard same cycle (FETCH_LAT=1) -> flush_if_id=flush_id_ex=1, stall_pc=0; next cycle all 0.
//  ex_mc_start then mc_done 6 cycles later -> stalls + flush_ex_mem high 6 cycles, all 0 on done cycle, back to RUN.
//  rst_n low mid MC_WAIT -> SQUASH immediately; with PIPE_CTRL_PERF_EN, 3 load-use events -> perf_stall_cyc=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID, ID/EX and EX/MEM pipe registers of the 5-stage core.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             stall_id_ex,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       dbg_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cyc
`endif
);

  localparam logic [1:0] ST_SQUASH  = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_MC_WAIT = 2'd2;

  localparam logic [2:0] LAT    = 3'(FETCH_LAT);
  localparam logic [2:0] LAT_M1 = 3'(FETCH_LAT - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] sq_cnt_q, sq_cnt_d;
  logic       load_use;
  logic       take_redirect;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    sq_cnt_d      = sq_cnt_q;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    take_redirect = 1'b0;
    case (state_q)
      ST_SQUASH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        sq_cnt_d    = sq_cnt_q - 3'd1;
        if (sq_cnt_q <= 3'd1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ex_redirect) begin
          take_redirect = 1'b1;
        end else if (ex_mc_start) begin
          state_d      = ST_MC_WAIT;
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else if (load_use) begin
          // EX receives the bubble next cycle, so the hazard cannot persist.
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (mc_done) begin
          state_d = ST_RUN;
          if (ex_redirect) take_redirect = 1'b1;
        end else begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end
      end
      default: begin
        state_d     = ST_SQUASH;
        sq_cnt_d    = LAT;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    endcase

    // A redirect squashes the wrong-path ID instr now; extra bubbles cover the fetch latency.
    if (take_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (FETCH_LAT > 1) begin
        state_d  = ST_SQUASH;
        sq_cnt_d = LAT_M1;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SQUASH;
      sq_cnt_q <= LAT;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // boot_q masks the post-reset squash so only redirect-driven flushes are counted.
  logic boot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q         <= 1'b0;
      perf_stall_cyc <= '0;
      perf_flush_cyc <= '0;
    end else begin
      if ((state_q == ST_SQUASH) && (state_d == ST_RUN)) boot_q <= 1'b1;
      if (stall_pc) perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
      if (flush_if_id && boot_q) perf_flush_cyc <= perf_flush_cyc + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (FETCH_LAT=1 and 2) share stimulus and are
// compared every cycle against a bubble-count reference model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_is_load = 1'b0;
  logic       ex_redirect = 1'b0, ex_mc_start = 1'b0, mc_done = 1'b0;

  logic s_pc1, s_ifid1, f_ifid1, s_idex1, f_idex1, f_exmem1;
  logic s_pc2, s_ifid2, f_ifid2, s_idex2, f_idex2, f_exmem2;
  logic [1:0] dbg1, dbg2;
  logic [5:0] got1, got2;
  assign got1 = {s_pc1, s_ifid1, f_ifid1, s_idex1, f_idex1, f_exmem1};
  assign got2 = {s_pc2, s_ifid2, f_ifid2, s_idex2, f_idex2, f_exmem2};

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] ps1, pf1, ps2, pf2;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FETCH_LAT(1), .CNT_W(32)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
    .mc_done(mc_done), .stall_pc(s_pc1), .stall_if_id(s_ifid1), .flush_if_id(f_ifid1),
    .stall_id_ex(s_idex1), .flush_id_ex(f_idex1), .flush_ex_mem(f_exmem1),
    .dbg_state(dbg1)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(ps1), .perf_flush_cyc(pf1)
`endif
  );

  pipe_hazard_ctrl #(.FETCH_LAT(2), .CNT_W(32)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
    .mc_done(mc_done), .stall_pc(s_pc2), .stall_if_id(s_ifid2), .flush_if_id(f_ifid2),
    .stall_id_ex(s_idex2), .flush_id_ex(f_idex2), .flush_ex_mem(f_exmem2),
    .dbg_state(dbg2)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(ps2), .perf_flush_cyc(pf2)
`endif
  );

  // Output vector order: {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem}
  localparam logic [5:0] V_IDLE  = 6'b000000;
  localparam logic [5:0] V_FLUSH = 6'b001010;
  localparam logic [5:0] V_MC    = 6'b110101;
  localparam logic [5:0] V_LU    = 6'b110010;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bubbles still owed, multi-cycle busy flag, perf counts.
  int  lat_of[2] = '{1, 2};
  int  m_sq[2];
  bit  m_mc[2];
  bit  m_boot[2];
  int  m_ps[2], m_pf[2];
  int  e_ps[2], e_pf[2];
  logic [11:0] exp_q[$];

  function automatic logic [5:0] model_out(int k);
    bit hazard;
    hazard = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_sq[k] > 0) return V_FLUSH;
    if (m_mc[k]) begin
      if (!mc_done) return V_MC;
      return ex_redirect ? V_FLUSH : V_IDLE;
    end
    if (ex_redirect) return V_FLUSH;
    if (ex_mc_start) return V_MC;
    if (hazard) return V_LU;
    return V_IDLE;
  endfunction

  task automatic model_next(int k, logic [5:0] o);
    if (o[5]) m_ps[k]++;
    if (o[3] && m_boot[k]) m_pf[k]++;
    if (m_sq[k] > 0) m_sq[k]--;
    else if (m_mc[k]) begin
      if (mc_done) begin
        m_mc[k] = 1'b0;
        if (ex_redirect) m_sq[k] = lat_of[k] - 1;
      end
    end else if (ex_redirect) m_sq[k] = lat_of[k] - 1;
    else if (ex_mc_start) m_mc[k] = 1'b1;
    if (m_sq[k] == 0) m_boot[k] = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sq[k] = lat_of[k]; m_mc[k] = 1'b0; m_boot[k] = 1'b0;
      m_ps[k] = 0; m_pf[k] = 0;
    end
  endtask

  // Drives one cycle of inputs, settles, and queues the model's expectation for that cycle.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic ld,
                       input logic rdr, input logic st, input logic dn);
    logic [5:0] o0, o1;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_redirect = rdr; ex_mc_start = st; mc_done = dn;
    #1;
    o0 = model_out(0);
    o1 = model_out(1);
    exp_q.push_back({o1, o0});
    for (int k = 0; k < 2; k++) begin
      e_ps[k] = m_ps[k];
      e_pf[k] = m_pf[k];
    end
    model_next(0, o0);
    model_next(1, o1);
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold_and_release();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({got2, got1} !== {V_FLUSH, V_FLUSH}) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required=%b", {got2, got1}, {V_FLUSH, V_FLUSH});
    end
    hold_and_release();
    $display("info: dbg_state after reset lat1=%0d lat2=%0d", dbg1, dbg2);
    for (int i = 0; i < 4; i++) begin
      idle();
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL reset_squash cyc=%0d got=%b required=%b", i, {got2, got1}, e);
      end
    end
  endtask

  task automatic test_load_use();
    logic [11:0] e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        1: idle();
        2: drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        3: drive(5'd1, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        4: drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        default: drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL load_use step=%0d got=%b required=%b", i, {got2, got1}, e);
      end
    end
  endtask

  task automatic test_redirect_hazard();
    logic [11:0] e;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      else idle();
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL redirect_hazard step=%0d got=%b required=%b", i, {got2, got1}, e);
      end
    end
  endtask

  task automatic test_multicycle();
    logic [11:0] e;
    // start, 5 waits (one with stray redirect, one with stray start), done, idle
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        2: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        3: drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        6: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        default: idle();
      endcase
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL multicycle step=%0d got=%b required=%b", i, {got2, got1}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    // mc_done together with redirect acts as a redirect; then another mc op right away
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        2: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        4: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        5: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        6: drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        default: idle();
      endcase
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL back_to_back step=%0d got=%b required=%b", i, {got2, got1}, e);
      end
    end
  endtask

  task automatic test_reset_mid_mc();
    logic [11:0] e;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if ({got2, got1} !== e) begin
      n_fail++;
      $display("FAIL mid_mc_wait got=%b required=%b", {got2, got1}, e);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({got2, got1} !== {V_FLUSH, V_FLUSH}) begin
      n_fail++;
      $display("FAIL async_reset_mid_mc got=%b required=%b", {got2, got1}, {V_FLUSH, V_FLUSH});
    end
    hold_and_release();
    for (int i = 0; i < 4; i++) begin
      idle();
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL post_reset_mc cyc=%0d got=%b required=%b", i, {got2, got1}, e);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) == 0));
      e = exp_q.pop_front();
      n_checks++;
      if ({got2, got1} !== e) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b required=%b", i, {got2, got1}, e);
      end
`ifdef PIPE_CTRL_PERF_EN
      n_checks++;
      if ({ps1, pf1, ps2, pf2} !== {32'(e_ps[0]), 32'(e_pf[0]), 32'(e_ps[1]), 32'(e_pf[1])}) begin
        n_fail++;
        $display("FAIL random_perf cyc=%0d got=%0d/%0d %0d/%0d required=%0d/%0d %0d/%0d",
                 i, ps1, pf1, ps2, pf2, e_ps[0], e_pf[0], e_ps[1], e_pf[1]);
      end
`endif
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    rst_n = 1'b0;
    hold_and_release();
    for (int i = 0; i < 3; i++) idle();
    for (int n = 0; n < 3; n++) begin
      drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
    end
    idle();
    exp_q.delete();
    n_checks++;
    if (ps1 !== 32'd3 || ps2 !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_stall_three got=%0d,%0d required=3", ps1, ps2);
    end
    n_checks++;
    if (pf1 !== 32'd0 || pf2 !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_flush_boot got=%0d,%0d required=0", pf1, pf2);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_redirect_hazard();
    test_multicycle();
    test_back_to_back();
    test_reset_mid_mc();
    test_random();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
